// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and buffered-entry layout for the instruction fetch stage.
package fetch_pkg;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam int FETCH_ENTRY_W = 65;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        misalign;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_buffer_sync_fifo.sv
// sync_fifo: circular FIFO with synchronous clear, simultaneous push/pop and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic                           clear,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wrData,
    output logic [WIDTH-1:0]               rdData,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic doPush, doPop;
    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign doPop = pop && !empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtr];
    always_ff @(posedge clk or negedge rstN)
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop) rdPtr <= nextPtr(rdPtr);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    always_ff @(posedge clk)
        if (doPush && !clear) mem[wrPtr] <= wrData;
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: issues word-aligned imem requests for currPC, tracks them in flight,
// and buffers returned instructions with their PC for decode; flush drops wrong-path work.
module inst_fetch_buffer #(
    parameter int          DEPTH    = 2,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic [31:0] currPC,
    output logic        pc_advance,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        flush,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_misalign
);
    import fetch_pkg::*;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int BW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(DEPTH + MAX_OUT + 1) + 1;
    fetch_entry_t head, respEntry;
    logic [32:0] reqTag, respTag;
    logic [OW-1:0] outstanding, dropCount;
    logic [BW-1:0] occupancy;
    logic bufFull, bufEmpty, pcqFull, pcqEmpty;
    logic accept, bufPush, bufPop, haveCredit;
    // requests already marked for drop do not hold a buffer slot
    assign haveCredit = CW'(occupancy) + CW'(outstanding) - CW'(dropCount) < CW'(DEPTH);
    assign imem_req_valid = reset_in && !flush && haveCredit && !pcqFull;
    assign imem_req_addr = {currPC[31:2], 2'b00};
    assign accept = imem_req_valid && imem_req_ready;
    assign pc_advance = accept;
    assign reqTag = {currPC, |currPC[1:0]};
    assign respEntry = '{pc: respTag[32:1], inst: imem_resp_data, misalign: respTag[0]};
    assign bufPush = imem_resp_valid && dropCount == '0 && !flush;
    assign bufPop = id_valid && id_ready && !flush;
    assign id_valid = !bufEmpty;
    assign id_inst = id_valid ? head.inst : NOP_INST;
    assign id_pc = id_valid ? head.pc : '0;
    assign id_pc_plus4 = id_pc + 32'd4;
    assign id_misalign = id_valid && head.misalign;
    sync_fifo #(.WIDTH(33), .DEPTH(MAX_OUT)) pcQueue (
        .clk(clock_in),
        .rstN(reset_in),
        .clear(1'b0),
        .push(accept),
        .pop(imem_resp_valid),
        .wrData(reqTag),
        .rdData(respTag),
        .full(pcqFull),
        .empty(pcqEmpty),
        .count(outstanding)
    );
    sync_fifo #(.WIDTH(FETCH_ENTRY_W), .DEPTH(DEPTH)) instBuffer (
        .clk(clock_in),
        .rstN(reset_in),
        .clear(flush),
        .push(bufPush),
        .pop(bufPop),
        .wrData(respEntry),
        .rdData(head),
        .full(bufFull),
        .empty(bufEmpty),
        .count(occupancy)
    );
    always_ff @(posedge clock_in or negedge reset_in)
        if (!reset_in) dropCount <= '0;
        else if (flush) dropCount <= outstanding - OW'(imem_resp_valid);
        else if (imem_resp_valid && dropCount != '0) dropCount <= dropCount - 1'b1;
    assert property (@(posedge clock_in) disable iff (!reset_in) !(bufPush && bufFull && !bufPop));
    assert property (@(posedge clock_in) disable iff (!reset_in) !(imem_resp_valid && pcqEmpty));
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: scoreboard bench with a single-cycle in-order memory model and an upstream Pc model.
module tb_inst_fetch_buffer;
    import fetch_pkg::*;
    logic clock_in = 1'b0;
    logic reset_in, imem_req_ready, imem_resp_valid, flush, id_ready;
    logic [31:0] currPC, imem_resp_data;
    logic pc_advance, imem_req_valid, id_valid, id_misalign;
    logic [31:0] imem_req_addr, id_inst, id_pc, id_pc_plus4;
    int checks = 0;
    int errors = 0;
    bit memEn = 1'b1;
    logic [31:0] memQ[$];
    fetch_entry_t expQ[$];

    always #5 clock_in = ~clock_in;

    inst_fetch_buffer #(.DEPTH(2), .MAX_OUT(2), .NOP_INST(NOP_INST)) dut (
        .clock_in(clock_in),
        .reset_in(reset_in),
        .currPC(currPC),
        .pc_advance(pc_advance),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .flush(flush),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_inst(id_inst),
        .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4),
        .id_misalign(id_misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h8C00_0000 | ((((a >> 2) + 32'd1) & 32'hFF) << 16) | (a & 32'hFFFF);
    endfunction

    // one clock: sample at negedge, score, then drive memory response and Pc update after the edge
    task automatic tick();
        fetch_entry_t e;
        logic acc;
        logic [31:0] addr;
        @(negedge clock_in);
        acc = imem_req_valid && imem_req_ready;
        addr = {currPC[31:2], 2'b00};
        if (imem_req_valid) check("req_addr", imem_req_addr, addr);
        if (flush) expQ.delete();
        else if (id_valid && id_ready) begin
            if (expQ.size() == 0) check("id_extra", {31'd0, id_valid}, 32'd0);
            else begin
                e = expQ.pop_front();
                check("id_pc", id_pc, e.pc);
                check("id_inst", id_inst, e.inst);
                check("id_misalign", {31'd0, id_misalign}, {31'd0, e.misalign});
                check("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
            end
        end
        if (acc) begin
            expQ.push_back('{pc: currPC, inst: memWord(addr), misalign: |currPC[1:0]});
            memQ.push_back(addr);
        end
        @(posedge clock_in);
        #1;
        if (acc) currPC = currPC + 32'd4;
        if (memEn && memQ.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data = memWord(memQ.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data = '0;
        end
    endtask

    task automatic expectHead(input string tag, input logic [31:0] pc, input logic [31:0] plus4);
        check({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
        check({tag, "_pc"}, id_pc, pc);
        check({tag, "_inst"}, id_inst, memWord(pc));
        check({tag, "_plus4"}, id_pc_plus4, plus4);
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!id_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_wait_valid"}, {31'd0, id_valid}, 32'd1);
    endtask

    task automatic drain(input string tag);
        imem_req_ready = 1'b0;
        id_ready = 1'b1;
        for (int i = 0; i < 20 && (expQ.size() > 0 || memQ.size() > 0 || imem_resp_valid); i++) tick();
        check({tag, "_left"}, 32'(expQ.size()), 32'd0);
        check({tag, "_idle"}, {31'd0, id_valid}, 32'd0);
    endtask

    task automatic fetchOne(input string tag, input logic [31:0] pc, input logic [31:0] expAddr);
        currPC = pc;
        imem_req_ready = 1'b1;
        #1;
        check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd1);
        check({tag, "_req_addr"}, imem_req_addr, expAddr);
        tick();
        imem_req_ready = 1'b0;
        waitValid(tag);
        check({tag, "_id_pc"}, id_pc, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in = 1'b0;
        currPC = 32'h0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        flush = 1'b0;
        id_ready = 1'b1;
        repeat (2) @(posedge clock_in);
        #1;
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_id_inst", id_inst, NOP_INST);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_plus4", id_pc_plus4, 32'h4);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_pc_advance", {31'd0, pc_advance}, 32'd0);
        reset_in = 1'b1;
        #3;
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        check("first_pc_advance", {31'd0, pc_advance}, 32'd1);
        tick();
        tick();
        expectHead("stream0", 32'h0, 32'h4);
        tick();
        expectHead("stream1", 32'h4, 32'h8);
        repeat (6) tick();
        id_ready = 1'b0;
        repeat (5) tick();
        check("bp_id_valid", {31'd0, id_valid}, 32'd1);
        check("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
        drain("bp_drain");
        currPC = 32'h10;
        memEn = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        tick();
        check("fl_two_out", 32'(memQ.size()), 32'd2);
        memEn = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data = memWord(memQ.pop_front());
        flush = 1'b1;
        #1;
        check("fl_no_req", {31'd0, imem_req_valid}, 32'd0);
        check("fl_no_adv", {31'd0, pc_advance}, 32'd0);
        tick();
        flush = 1'b0;
        currPC = 32'h40;
        waitValid("fl");
        check("fl_pc", id_pc, 32'h40);
        drain("fl_drain");
        imem_req_ready = 1'b1;
        flush = 1'b1;
        #1;
        check("idle_flush_req", {31'd0, imem_req_valid}, 32'd0);
        flush = 1'b0;
        #1;
        check("idle_req", {31'd0, imem_req_valid}, 32'd1);
        imem_req_ready = 1'b0;
        fetchOne("mis", 32'h1B, 32'h18);
        check("mis_flag", {31'd0, id_misalign}, 32'd1);
        drain("mis_drain");
        fetchOne("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        check("wrap_plus4", id_pc_plus4, 32'h0);
        check("wrap_mis", {31'd0, id_misalign}, 32'd0);
        drain("wrap_drain");
        currPC = 32'h100;
        imem_req_ready = 1'b1;
        id_ready = 1'b0;
        tick();
        memEn = 1'b0;
        tick();
        check("mr_pre_valid", {31'd0, id_valid}, 32'd1);
        check("mr_pre_out", 32'(memQ.size()), 32'd1);
        #2;
        reset_in = 1'b0;
        imem_resp_valid = 1'b0;
        memQ.delete();
        expQ.delete();
        #1;
        check("mr_id_valid", {31'd0, id_valid}, 32'd0);
        check("mr_id_inst", id_inst, NOP_INST);
        check("mr_id_pc", id_pc, 32'h0);
        check("mr_id_plus4", id_pc_plus4, 32'h4);
        check("mr_id_mis", {31'd0, id_misalign}, 32'd0);
        check("mr_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("mr_pc_advance", {31'd0, pc_advance}, 32'd0);
        @(posedge clock_in);
        #1;
        currPC = 32'h200;
        memEn = 1'b1;
        id_ready = 1'b1;
        imem_req_ready = 1'b1;
        reset_in = 1'b1;
        waitValid("mr");
        check("mr_restart_pc", id_pc, 32'h200);
        repeat (4) tick();
        drain("mr_drain");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
